// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch engine.
// FSM states, FIFO entry layout and PC step.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read bus and decode-side handshake.
// master = fetch engine, slave = memory/decode environment.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int LENGTH = XLEN
);

  logic              imem_req;
  logic [LENGTH-1:0] imem_addr;
  logic              imem_ack;
  logic [LENGTH-1:0] imem_data;
  logic              inst_valid;
  logic [LENGTH-1:0] inst_data;
  logic [LENGTH-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data,
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {inst, pc} entries.
// clear wins over push/pop; pop on empty is ignored.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t entry_in,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_pop;

  assign do_pop = pop & (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= entry_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch engine: one outstanding imem read at the
// current PC, results queued toward decode, flush discards all.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int LENGTH = XLEN,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [LENGTH-1:0] pc,
  output logic              pc_adv,
  input  logic              flush,
  fetch_if.master           bus
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t      state;
  logic [LENGTH-1:0] addr_q;
  logic              req_q;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_after;
  logic              pop;
  logic              room_now;
  logic              room_after;
  fetch_entry_t      wr_entry;
  fetch_entry_t      head;

  assign pop         = bus.inst_valid & bus.inst_ready;
  assign pc_adv      = (state == REQ) & bus.imem_ack & ~flush;
  assign count_after = count + CW'(pc_adv) - CW'(pop);
  assign room_now    = count < CW'(DEPTH);
  assign room_after  = count_after < CW'(DEPTH);
  assign wr_entry    = '{inst: bus.imem_data, pc: addr_q};

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = count != '0;
  assign bus.inst_data  = head.inst;
  assign bus.inst_pc    = head.pc;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (flush),
    .push     (pc_adv),
    .pop      (pop),
    .entry_in (wr_entry),
    .count    (count),
    .head     (head)
  );

  // The next address is pc+STEP because pc_adv bumps pc on this same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      addr_q <= '0;
      req_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!flush && room_now) begin
            state  <= REQ;
            addr_q <= pc;
            req_q  <= 1'b1;
          end
        end
        REQ: begin
          if (flush) begin
            state <= bus.imem_ack ? IDLE : DROP;
            req_q <= ~bus.imem_ack;
          end else if (bus.imem_ack) begin
            if (room_after) begin
              addr_q <= pc + LENGTH'(PC_STEP);
            end else begin
              state <= IDLE;
              req_q <= 1'b0;
            end
          end
        end
        DROP: begin
          if (bus.imem_ack) begin
            state <= IDLE;
            req_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: pc register + fixed-latency memory around the
// DUT, in-order stream scoreboard, directed and random phases.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc;
  logic        pc_adv;
  logic        flush;
  logic [31:0] tgt;
  int unsigned lat;
  int unsigned wait_cnt;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_pc = '0;
  logic        flush_d = 1'b0;
  logic        found;
  logic [31:0] prev_addr;

  fetch_if bus ();

  fetch_unit #(.LENGTH(32), .DEPTH(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pc      (pc),
    .pc_adv  (pc_adv),
    .flush   (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memory: ack after lat cycles of a held request
  always_comb begin
    bus.imem_ack  = bus.imem_req && (wait_cnt >= lat);
    bus.imem_data = mem_word(bus.imem_addr);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) wait_cnt <= 0;
    else if (bus.imem_req) wait_cnt <= bus.imem_ack ? 0 : wait_cnt + 1;
  end

  // pc register
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc <= '0;
    else if (flush) pc <= tgt;
    else if (pc_adv) pc <= pc + 32'd4;
  end

  // decode sees target, target+4, ... with no gap, loss or duplicate
  always @(negedge clk) begin
    if (reset_n) begin
      if (flush_d) chk("flush_empty", bus.inst_valid, 1'b0);
      if (bus.inst_valid && bus.inst_ready) begin
        chk("inst_pc", bus.inst_pc, exp_pc);
        chk("inst_data", bus.inst_data, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      if (flush) exp_pc = tgt;
      flush_d = flush;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    flush = 1'b0;
    tgt = '0;
    bus.inst_ready = 1'b0;
    lat = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    lat = 5;
    @(negedge clk);
    chk("boot_idle_req", bus.imem_req, 1'b0);
    @(negedge clk);
    chk("boot_req", bus.imem_req, 1'b1);
    chk("boot_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_valid", bus.inst_valid, 1'b0);
    chk("rst_adv", pc_adv, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_hold_req", bus.imem_req, 1'b0);
    exp_pc = '0;
    lat = 0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_idle_req", bus.imem_req, 1'b0);
    @(negedge clk);
    chk("rel_req", bus.imem_req, 1'b1);
    chk("rel_addr", bus.imem_addr, 32'h0);

    // backpressure: two entries then stall at pc 8
    repeat (3) @(negedge clk);
    chk("bp_valid", bus.inst_valid, 1'b1);
    chk("bp_head_pc", bus.inst_pc, 32'h0);
    chk("bp_head_data", bus.inst_data, mem_word(32'h0));
    chk("bp_req", bus.imem_req, 1'b0);
    chk("bp_pc", pc, 32'h8);
    @(posedge clk);
    #1 bus.inst_ready = 1'b1;

    // stream: one instruction per cycle
    repeat (6) @(negedge clk);
    prev_addr = bus.imem_addr;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stream_valid", bus.inst_valid, 1'b1);
      chk("stream_adv", pc_adv, 1'b1);
      chk("stream_addr", bus.imem_addr, prev_addr + 32'd4);
      prev_addr = bus.imem_addr;
    end

    // flush in flight at pc 8
    @(posedge clk);
    #1 flush = 1'b1;
    tgt = 32'h8;
    lat = 3;
    @(posedge clk);
    #1 flush = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      found = bus.imem_req && bus.imem_addr == 32'h8;
    end
    chk("f4_reach8", found, 1'b1);
    @(posedge clk);
    #1 flush = 1'b1;
    tgt = 32'hcacaffff;
    @(negedge clk);
    chk("f4_pc", pc, 32'h8);
    chk("f4_no_ack", bus.imem_ack, 1'b0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("f4_drop_req", bus.imem_req, 1'b1);
    chk("f4_drop_addr", bus.imem_addr, 32'h8);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bus.imem_req && bus.imem_addr == 32'hcacaffff;
    end
    chk("f4_redirect", found, 1'b1);

    // flush coinciding with ack
    @(posedge clk);
    #1 lat = 0;
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1 flush = 1'b1;
    tgt = 32'h0000_1000;
    @(negedge clk);
    chk("f5_ack", bus.imem_ack, 1'b1);
    chk("f5_adv", pc_adv, 1'b0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("f5_pc", pc, 32'h0000_1000);
    chk("f5_valid", bus.inst_valid, 1'b0);
    chk("f5_idle", bus.imem_req, 1'b0);
    @(negedge clk);
    chk("f5_req", bus.imem_req, 1'b1);
    chk("f5_addr", bus.imem_addr, 32'h0000_1000);

    // pc wrap
    @(posedge clk);
    #1 flush = 1'b1;
    tgt = 32'hffff_fff8;
    @(posedge clk);
    #1 flush = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bus.imem_req && bus.imem_addr == 32'hffff_fffc;
    end
    chk("wrap_reach", found, 1'b1);
    @(negedge clk);
    chk("wrap_req", bus.imem_req, 1'b1);
    chk("wrap_addr", bus.imem_addr, 32'h0);
    repeat (12) @(negedge clk);

    // random ready / flush / latency
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      bus.inst_ready = ($urandom % 10) < 7;
      flush = ($urandom % 40) == 0;
      tgt = $urandom;
      if (($urandom % 50) == 0) lat = $urandom % 4;
    end

    @(posedge clk);
    #1 flush = 1'b0;
    bus.inst_ready = 1'b1;
    lat = 0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("live_rate", bus.inst_valid & pc_adv, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
